// File: rtl/iq_sched_pkg.sv
// Shared types and default constants for the iq_demod sample scheduler.
package iq_sched_pkg;

    // Scheduler states: waiting, filling the FIFO, issuing slots, emptying before idle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // One I/Q IF sample pair as it travels through the FIFO.
    typedef struct packed {
        logic [3:0] i;
        logic [3:0] q;
    } iq_sample_t;

    localparam int DIV_DEF       = 5;
    localparam int LAT_MAX_DEF   = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int PRIME_LVL_DEF = 2;

    // Builds a sample record from the two ADC nibbles.
    function automatic iq_sample_t pack_sample(input logic [3:0] i_val, input logic [3:0] q_val);
        iq_sample_t s;
        s.i = i_val;
        s.q = q_val;
        return s;
    endfunction

endpackage

// File: rtl/iq_sample_fifo.sv
// Small synchronous FIFO holding I/Q sample pairs; head is visible combinationally
// so the scheduler can register it straight into its output stage on a pop.
module iq_sample_fifo
    import iq_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          srst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO only lands if a pop frees a slot in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write; left without reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and fill-level bookkeeping; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/iq_demod_sched.sv
// Sample scheduler in front of iq_demod: buffers ADC samples, hands one pair to the
// demodulator per conversion slot, and watches the sample_ready return path.
module iq_demod_sched
    import iq_sched_pkg::*;
#(
    parameter int DIV       = DIV_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PRIME_LVL = PRIME_LVL_DEF,
    parameter int LAT_MAX   = LAT_MAX_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        in_valid,
    input  logic [3:0]  in_i,
    input  logic [3:0]  in_q,
    output logic        eoc,
    output logic [3:0]  I_IF,
    output logic [3:0]  Q_IF,
    input  logic        sample_ready,
    output logic        busy,
    output logic        err_underrun,
    output logic        err_overrun,
    output logic        err_timeout,
    output logic [15:0] eoc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = AW + 2;
    localparam logic [7:0]    DIV_LAST    = 8'(DIV - 1);
    localparam logic [7:0]    LAT_MAX_W   = 8'(LAT_MAX);
    localparam logic [AW:0]   PRIME_LVL_W = LW'(PRIME_LVL);

    sched_state_t r_state;
    sched_state_t w_state_next;

    logic [7:0]    r_div;
    logic          r_eoc;
    logic [3:0]    r_i;
    logic [3:0]    r_q;
    logic [15:0]   r_eoc_count;
    logic          r_err_under;
    logic          r_err_over;
    logic          r_err_to;
    logic [OW-1:0] r_outstanding;
    logic [7:0]    r_age;

    iq_sample_t    w_in_sample;
    iq_sample_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_level;
    logic          w_slot_active;
    logic          w_slot_end;
    logic          w_pop;
    logic          w_overrun;
    logic          w_underrun;
    logic          w_start_ok;
    logic          w_inc;
    logic          w_dec;
    logic [OW-1:0] w_out_sum;
    logic          w_reload;
    logic          w_timeout;

    assign w_in_sample   = pack_sample(in_i, in_q);
    assign w_slot_active = (r_state == RUN) || (r_state == DRAIN);
    assign w_slot_end    = w_slot_active && (r_div == DIV_LAST);
    assign w_pop         = w_slot_end && !w_empty;
    assign w_overrun     = in_valid && w_full && !w_pop;
    assign w_underrun    = w_slot_end && w_empty && (r_state == RUN);
    assign w_start_ok    = (r_state == IDLE) && start && !stop;

    iq_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (reset),
        .i_push  (in_valid),
        .i_data  (w_in_sample),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; stop always takes precedence over start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (start && !stop) w_state_next = PRIME;
            PRIME: begin
                if (stop)                        w_state_next = IDLE;
                else if (w_level >= PRIME_LVL_W) w_state_next = RUN;
            end
            RUN:   if (stop) w_state_next = DRAIN;
            DRAIN: if (w_slot_end && w_empty && (r_outstanding == '0)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Slot divider: free-runs 0..DIV-1 while slots are active, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_slot_active && (w_state_next != IDLE)) begin
            r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
        end else begin
            r_div <= '0;
        end
    end

    // Output stage: eoc and the sample move together, sample forced to zero off-slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_eoc       <= 1'b0;
            r_i         <= '0;
            r_q         <= '0;
            r_eoc_count <= '0;
        end else begin
            r_eoc <= w_pop;
            r_i   <= w_pop ? w_head.i : 4'd0;
            r_q   <= w_pop ? w_head.q : 4'd0;
            if (w_pop) r_eoc_count <= r_eoc_count + 16'd1;
        end
    end

    // Latency tracker arithmetic: net outstanding change, timer reload and expiry.
    always_comb begin
        w_inc     = r_eoc;
        w_dec     = sample_ready && (r_outstanding != '0);
        w_out_sum = r_outstanding;
        if (w_inc && !w_dec && (r_outstanding != '1)) w_out_sum = r_outstanding + 1'b1;
        else if (!w_inc && w_dec)                     w_out_sum = r_outstanding - 1'b1;
        w_reload  = (w_inc && (r_outstanding == '0)) || (w_dec && (w_out_sum != '0));
        // r_age counts clocks since the last reload; reaching LAT_MAX here means the
        // age would exceed LAT_MAX at the coming edge with work still outstanding.
        w_timeout = (w_out_sum != '0) && !w_reload && (r_age >= LAT_MAX_W);
    end

    // Latency tracker state; a timeout abandons every outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_age         <= '0;
        end else if (w_timeout) begin
            r_outstanding <= '0;
            r_age         <= '0;
        end else begin
            r_outstanding <= w_out_sum;
            if (w_reload)                                r_age <= 8'd1;
            else if ((w_out_sum != '0) && (r_age != '1)) r_age <= r_age + 8'd1;
        end
    end

    // Sticky error flags; a new error in the same cycle as an accepted start still sticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_under <= 1'b0;
            r_err_over  <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_err_under <= 1'b0;
                r_err_over  <= 1'b0;
                r_err_to    <= 1'b0;
            end
            if (w_underrun) r_err_under <= 1'b1;
            if (w_overrun)  r_err_over  <= 1'b1;
            if (w_timeout)  r_err_to    <= 1'b1;
        end
    end

    assign eoc          = r_eoc;
    assign I_IF         = r_i;
    assign Q_IF         = r_q;
    assign busy         = (r_state != IDLE);
    assign err_underrun = r_err_under;
    assign err_overrun  = r_err_over;
    assign err_timeout  = r_err_to;
    assign eoc_count    = r_eoc_count;

endmodule

// File: tb/tb_iq_demod_sched.sv
// Bench for iq_demod_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based behavioural model.
module tb_iq_demod_sched;

    localparam int DIV       = 5;
    localparam int DEPTH     = 4;
    localparam int PRIME_LVL = 2;
    localparam int LAT_MAX   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        sample_ready = 1'b0;
    logic [3:0]  in_i = 4'd0;
    logic [3:0]  in_q = 4'd0;
    logic        eoc, busy, err_underrun, err_overrun, err_timeout;
    logic [3:0]  I_IF, Q_IF;
    logic [15:0] eoc_count;

    always #10 clk = ~clk;

    iq_demod_sched #(
        .DIV(DIV), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL), .LAT_MAX(LAT_MAX)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .eoc(eoc), .I_IF(I_IF), .Q_IF(Q_IF), .sample_ready(sample_ready),
        .busy(busy), .err_underrun(err_underrun), .err_overrun(err_overrun),
        .err_timeout(err_timeout), .eoc_count(eoc_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: state 0=idle 1=prime 2=run 3=drain, FIFO as a queue,
    // latency age tracked as a cycle stamp of the last reload.
    int         m_state, m_div, m_cnt, m_out, m_ref;
    bit         m_eoc, m_under, m_over, m_to;
    logic [3:0] m_i, m_q;
    logic [7:0] m_fifo[$];

    int cyc = 0;
    int sr_lat = 3;
    int sr_due[$];
    int eoc_cyc[$];
    int eoc_i[$];
    int eoc_q[$];

    task automatic model_reset();
        m_state = 0; m_div = 0; m_cnt = 0; m_out = 0; m_ref = 0;
        m_eoc = 0; m_under = 0; m_over = 0; m_to = 0; m_i = 0; m_q = 0;
        m_fifo.delete();
    endtask

    task automatic model_step();
        bit slot_end, pop, drop, inc, dec, reload, tmo;
        logic [7:0] head;
        int out_after, nxt, lvl;
        if (reset) begin
            model_reset();
            return;
        end
        lvl      = m_fifo.size();
        slot_end = (m_state >= 2) && (m_div == DIV - 1);
        pop      = slot_end && (lvl > 0);
        head     = pop ? m_fifo[0] : 8'h00;
        drop     = in_valid && (lvl == DEPTH) && !pop;
        inc      = m_eoc;
        dec      = sample_ready && (m_out > 0);
        out_after = m_out + (inc ? 1 : 0) - (dec ? 1 : 0);
        reload   = (inc && m_out == 0) || (dec && out_after > 0);
        tmo      = (out_after > 0) && !reload && ((cyc - m_ref) >= LAT_MAX);
        nxt = m_state;
        case (m_state)
            0: if (start && !stop) nxt = 1;
            1: if (stop) nxt = 0; else if (lvl >= PRIME_LVL) nxt = 2;
            2: if (stop) nxt = 3;
            default: if (slot_end && lvl == 0 && m_out == 0) nxt = 0;
        endcase
        if (m_state == 0 && start && !stop) begin
            m_under = 0; m_over = 0; m_to = 0;
        end
        if (drop) m_over = 1;
        if (slot_end && lvl == 0 && m_state == 2) m_under = 1;
        if (tmo) m_to = 1;
        m_eoc = pop;
        m_i   = pop ? head[7:4] : 4'd0;
        m_q   = pop ? head[3:0] : 4'd0;
        if (pop) m_cnt = (m_cnt + 1) & 16'hFFFF;
        m_div = (m_state >= 2 && nxt >= 2) ? (m_div + 1) % DIV : 0;
        m_out = tmo ? 0 : out_after;
        if (reload) m_ref = cyc;
        if (pop) void'(m_fifo.pop_front());
        if (in_valid && !drop) m_fifo.push_back({in_i, in_q});
        m_state = nxt;
    endtask

    // One clock: drive inputs, step the model on the edge, compare just after it.
    task automatic cyc_run(input bit s, input bit p, input bit v,
                           input logic [3:0] di, input logic [3:0] dq, input bit spur);
        logic [31:0] got_v, exp_v;
        start = s; stop = p; in_valid = v; in_i = di; in_q = dq;
        sample_ready = spur;
        for (int k = sr_due.size() - 1; k >= 0; k--) begin
            if (sr_due[k] <= cyc) begin
                if (sr_due[k] == cyc) sample_ready = 1'b1;
                sr_due.delete(k);
            end
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        got_v = {3'b0, eoc, I_IF, Q_IF, busy, err_underrun, err_overrun, err_timeout, eoc_count};
        exp_v = {3'b0, m_eoc, m_i, m_q, (m_state != 0), m_under, m_over, m_to, 16'(m_cnt)};
        chk("outs", got_v, exp_v);
        if (eoc) begin
            $display("eoc n=%0d t=%0d I=%0d Q=%0d", eoc_count, cyc, I_IF, Q_IF);
            eoc_cyc.push_back(cyc);
            eoc_i.push_back(int'(I_IF));
            eoc_q.push_back(int'(Q_IF));
            if (sr_lat > 0) sr_due.push_back(cyc + sr_lat);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc_run(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic push(input logic [3:0] di, input logic [3:0] dq);
        cyc_run(1'b0, 1'b0, 1'b1, di, dq, 1'b0);
    endtask

    task automatic clear_log();
        eoc_cyc.delete(); eoc_i.delete(); eoc_q.delete();
    endtask

    task automatic stop_and_wait(input string tag);
        cyc_run(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 20 && busy; k++) idle(1);
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, e, s;
        model_reset();

        // Reset state
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst_state", {11'b0, eoc, busy, err_underrun, err_overrun, err_timeout, eoc_count},
            32'd0);

        // Basic scheduling of three samples
        clear_log(); sr_lat = 3;
        cyc_run(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        push(4'd1, 4'd2);
        idle(1);
        x = cyc;
        push(4'd3, 4'd4);
        idle(1);
        push(4'd5, 4'd6);
        idle(25);
        chk("t1_neoc", eoc_cyc.size(), 32'd3);
        if (eoc_cyc.size() >= 3) begin
            chk("t1_first_lat", eoc_cyc[0] - x, 32'd7);
            chk("t1_sp1", eoc_cyc[1] - eoc_cyc[0], 32'd5);
            chk("t1_sp2", eoc_cyc[2] - eoc_cyc[1], 32'd5);
            chk("t1_s0", {eoc_i[0][3:0], eoc_q[0][3:0]}, 32'h12);
            chk("t1_s1", {eoc_i[1][3:0], eoc_q[1][3:0]}, 32'h34);
            chk("t1_s2", {eoc_i[2][3:0], eoc_q[2][3:0]}, 32'h56);
        end
        chk("t1_count", 32'(eoc_count), 32'd3);
        stop_and_wait("t1_idle");

        // Overrun while priming
        clear_log();
        cyc_run(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 6; k++) push(4'(k), 4'(15 - k));
        chk("t2_over", 32'(err_overrun), 32'd1);
        idle(30);
        chk("t2_neoc", eoc_cyc.size(), 32'd4);
        if (eoc_cyc.size() >= 4)
            for (int k = 0; k < 4; k++)
                chk("t2_order", {eoc_i[k][3:0], eoc_q[k][3:0]}, {4'(k + 1), 4'(14 - k)});
        stop_and_wait("t2_idle");

        // Underrun and preserved slot timing
        clear_log();
        cyc_run(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("t3_clr", {err_underrun, err_overrun, err_timeout}, 32'd0);
        push(4'd7, 4'd8);
        push(4'd9, 4'd10);
        for (int k = 0; k < 40 && eoc_cyc.size() < 2; k++) idle(1);
        chk("t3_pre", eoc_cyc.size(), 32'd2);
        e = (eoc_cyc.size() >= 2) ? eoc_cyc[1] : cyc;
        for (int k = 0; k < 10 && cyc < e + 6; k++) idle(1);
        chk("t3_under", 32'(err_underrun), 32'd1);
        push(4'd11, 4'd12);
        idle(12);
        chk("t3_neoc", eoc_cyc.size(), 32'd3);
        if (eoc_cyc.size() >= 3) begin
            chk("t3_gap", eoc_cyc[2] - eoc_cyc[1], 32'd10);
            chk("t3_s", {eoc_i[2][3:0], eoc_q[2][3:0]}, 32'hBC);
        end
        chk("t3_noto", 32'(err_timeout), 32'd0);

        // Timeout when sample_ready is withheld
        clear_log(); sr_lat = 0;
        push(4'd13, 4'd14);
        for (int k = 0; k < 20 && eoc_cyc.size() < 1; k++) idle(1);
        e = (eoc_cyc.size() >= 1) ? eoc_cyc[0] : cyc;
        for (int k = 0; k < 40 && !err_timeout; k++) idle(1);
        chk("t4_to", 32'(err_timeout), 32'd1);
        chk("t4_when", cyc - e, 32'd17);
        sr_lat = 3;
        stop_and_wait("t4_idle");

        // Stop with two samples buffered
        clear_log();
        cyc_run(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        push(4'd2, 4'd3);
        push(4'd4, 4'd5);
        idle(1);
        cyc_run(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 40 && busy; k++) idle(1);
        s = cyc;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_neoc", eoc_cyc.size(), 32'd2);
        if (eoc_cyc.size() >= 2) begin
            chk("t5_sp", eoc_cyc[1] - eoc_cyc[0], 32'd5);
            chk("t5_fall", s - eoc_cyc[1], 32'd5);
        end
        chk("t5_under", 32'(err_underrun), 32'd0);

        // Reset mid-RUN with three samples buffered
        cyc_run(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        push(4'd1, 4'd1);
        push(4'd2, 4'd2);
        push(4'd3, 4'd3);
        reset = 1'b1;
        sr_due.delete();
        idle(1);
        reset = 1'b0;
        chk("t6_rst", {11'b0, eoc, busy, err_underrun, err_overrun, err_timeout, eoc_count},
            32'd0);
        cyc_run(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(20);
        chk("t6_count", 32'(eoc_count), 32'd0);
        chk("t6_prime", 32'(busy), 32'd1);
        stop_and_wait("t6_idle");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit rs, rp, rv, rsp;
            if (n % 500 == 0) sr_lat = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
            rs  = ($urandom_range(0, 99) < 3);
            rp  = ($urandom_range(0, 199) < 2);
            rv  = ($urandom_range(0, 99) < 25);
            rsp = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 999) < 2);
            if (reset) sr_due.delete();
            cyc_run(rs, rp, rv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rsp);
        end
        reset = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_demod_sched.md
Name: iq_demod_sched

Overview:
- Sample scheduler and sequencer in front of iq_demod.
- Buffers 4-bit I/Q IF samples from the ADC capture path in a small FIFO.
- Issues one eoc strobe every DIV clocks, presenting exactly one I/Q pair to the demodulator on the eoc cycle.
- Watches iq_demod's sample_ready return and flags underrun, overrun and latency timeout.

Parameters:
- DIV, 5, clocks per conversion slot (50 MHz / 5 = 10 MS/s); legal 2..255.
- DEPTH, 4, FIFO entries; power of 2, 2..16.
- PRIME_LVL, 2, FIFO level required before the first eoc; 1..DEPTH.
- LAT_MAX, 16, maximum clocks from eoc to matching sample_ready; 1..255.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begin scheduling
- stop  in  1  one-cycle pulse, drain FIFO and return to idle
- in_valid  in  1  ADC sample strobe; no backpressure
- in_i  in  4  I_IF sample
- in_q  in  4  Q_IF sample
- eoc  out  1  conversion strobe to iq_demod
- I_IF  out  4  I sample to iq_demod; zero when eoc=0
- Q_IF  out  4  Q sample to iq_demod; zero when eoc=0
- sample_ready  in  1  iq_demod output-valid pulse
- busy  out  1  state != IDLE
- err_underrun  out  1  sticky
- err_overrun  out  1  sticky
- err_timeout  out  1  sticky
- eoc_count  out  16  number of eocs issued; wraps modulo 2^16

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; divider 0; sticky flags cleared; outstanding counter 0. Reset mid-operation aborts immediately; FIFO contents are discarded.
- FIFO:
  - Pushes whenever in_valid=1, in every state.
  - If full and no pop occurs that cycle, the sample is dropped and err_overrun is set.
  - Push and pop in the same cycle when full is legal: no drop.
  - Registered outputs: eoc, I_IF and Q_IF all change on the same clk edge.
- States:
  - IDLE: divider held at 0. start -> PRIME.
  - PRIME: when FIFO level >= PRIME_LVL -> RUN with divider 0. stop -> IDLE.
  - RUN:
    - Divider counts 0..DIV-1 and wraps.
    - When divider == DIV-1: if FIFO is non-empty, pop; the next cycle has eoc=1 with I_IF/Q_IF = head sample, and eoc_count increments.
    - If the FIFO is empty at that point: no eoc, I/Q stay 0, err_underrun is set, and the slot timing is preserved.
    - stop -> DRAIN.
  - DRAIN: same slot timing as RUN. Once the FIFO is empty at a slot boundary and outstanding == 0 -> IDLE. Underrun is not flagged in DRAIN.
- start while not IDLE is ignored. stop and start in the same cycle: stop wins.
- Spacing: eoc never asserts on two consecutive cycles; minimum spacing is DIV clocks.
- Latency tracker:
  - Outstanding counter (width clog2(DEPTH)+2): +1 on eoc, -1 on sample_ready; simultaneous +1/-1 nets to 0.
  - Age timer: reloaded on eoc when outstanding == 0, and on each sample_ready while outstanding remains > 0.
  - If the timer exceeds LAT_MAX while outstanding > 0: set err_timeout and clear outstanding to 0.
  - sample_ready with outstanding == 0 is ignored.
- Sticky flags clear only on reset or on a start accepted in IDLE.

Decomposition:
- Package iq_sched_pkg:
  - state enum typedef (IDLE, PRIME, RUN, DRAIN)
  - iq_sample_t packed struct {logic [3:0] i; logic [3:0] q;}
  - default constants DIV_DEF = 5 and LAT_MAX_DEF = 16
- Natural sub-module: iq_sample_fifo, a synchronous DEPTH x 8-bit FIFO with push/pop, full/empty and level outputs.
- Top level holds the FSM, divider, latency tracker and flags.

Test Plan:
- Reset, then start, then in_valid pulses with samples (1,2), (3,4), (5,6).
  -> First eoc 1 cycle after the first slot boundary following level>=2, with I_IF=1, Q_IF=2.
  -> Subsequent eocs exactly 5 clks apart carry (3,4) then (5,6); eoc_count=3.
- Feed 6 samples back-to-back while in PRIME with DEPTH=4.
  -> Samples 5 and 6 are dropped and err_overrun=1.
  -> The first four samples emerge in order.
- RUN with one sample buffered and no further input.
  -> Second slot has no eoc and I_IF=Q_IF=0; err_underrun=1; next slot timing remains 5 clks.
- RUN, with sample_ready returned 3 clks after each eoc.
  -> No err_timeout. Withholding sample_ready -> err_timeout=1 exactly at 17 clks after the eoc, and outstanding returns to 0.
- stop with 2 samples buffered.
  -> Two more eocs 5 clks apart; busy drops after the last sample_ready; no err_underrun.
- reset asserted mid-RUN with the FIFO holding 3 samples.
  -> Next cycle: eoc=0, busy=0, flags 0, eoc_count=0.
  -> A subsequent start requires fresh priming.
